// File: rtl/counter_bcd_mod_if.sv
// -----------------------------------------------------------------------------
// counter_bcd_mod_if
// Bus bundle for one BCD modulo counter stage.
//
// Signal semantics (one comment for the whole bundle):
//   clr, load and en are level strobes, sampled on every rising clock edge.
//   No valid/ready handshake exists: the counter is always ready, and a strobe
//   that is high at an edge is consumed at that edge. Priority is
//   clr > load > en. cnt, wrap and load_err are registered. tc and carry are
//   combinational from cnt (and en) in the same cycle.
//
// Ports (per modport):
//   clr       control -> counter   synchronous clear to 0
//   en        control -> counter   count enable, one step per cycle
//   up        control -> counter   direction (1 = up), used only with down mode
//   load      control -> counter   synchronous preset strobe
//   load_val  control -> counter   BCD preset value, digit 0 in [3:0]
//   cnt       counter -> control   BCD count
//   tc        counter -> control   terminal count
//   carry     counter -> control   cascade carry/borrow (en & tc)
//   wrap      counter -> control   1-cycle pulse after a wrap step
//   load_err  counter -> control   1-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
interface counter_bcd_mod_if #(
  parameter int DIGITS = 2
);
  logic                clr;
  logic                en;
  logic                up;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] cnt;
  logic                tc;
  logic                carry;
  logic                wrap;
  logic                load_err;

  modport master (
    output clr, en, up, load, load_val,
    input  cnt, tc, carry, wrap, load_err
  );

  modport slave (
    input  clr, en, up, load, load_val,
    output cnt, tc, carry, wrap, load_err
  );
endinterface

// File: rtl/counter_bcd_mod.sv
// -----------------------------------------------------------------------------
// counter_bcd_mod
// Parametrised multi-digit BCD modulo counter with synchronous clear, validated
// BCD preset, terminal count, cascade carry and wrap / load-error pulses.
// Stages cascade by wiring carry of one stage to en of the next.
//
// Parameters:
//   DIGITS   number of BCD digits (1..4); count width is 4*DIGITS
//   MODULUS  count range 0..MODULUS-1 (2..10**DIGITS)
//
// Ports:
//   clk   in  system clock, all state on the rising edge
//   rst   in  synchronous reset, active-high
//   bus   counter_bcd_mod_if.slave: clr, en, up, load, load_val in;
//         cnt, tc, carry, wrap, load_err out
//
// Configuration macro: COUNTER_BCD_DOWN_EN
//   defined   : bus.up selects the direction; down mode wraps 0 -> MAX and
//               its terminal count is cnt == 0.
//   undefined : bus.up is ignored, the counter always counts up.
// -----------------------------------------------------------------------------
module counter_bcd_mod #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic             clk,
  input  logic             rst,
  counter_bcd_mod_if.slave bus
);
  localparam int W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("counter_bcd_mod: DIGITS must be 1..4");
  end
  if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
    $error("counter_bcd_mod: MODULUS must be 2..10**DIGITS");
  end

  function automatic logic digits_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // One BCD step in the chosen direction. A digit only moves while every lower
  // digit rolled over (9 -> 0 going up, 0 -> 9 going down).
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v,
                                            input logic       up_dir);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (up_dir) begin
          if (v[4*k +: 4] == 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = v[4*k +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*k +: 4] == 4'd0) begin
            r[4*k +: 4] = 4'd9;
          end else begin
            r[4*k +: 4] = v[4*k +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] cnt_q;
  logic         wrap_q;
  logic         load_err_q;
  logic         dir_up;
  logic         at_end;
  logic         cnt_ok;
  logic         load_ok;
  logic [W-1:0] cnt_step;

`ifdef COUNTER_BCD_DOWN_EN
  assign dir_up = bus.up;
`else
  logic unused_up;
  assign unused_up = bus.up;
  assign dir_up    = 1'b1;
`endif

  // With all digits <= 9, unsigned comparison of the BCD vectors matches the
  // decimal ordering, so the range check needs no binary conversion.
  assign at_end   = dir_up ? (cnt_q == MAX_BCD) : (cnt_q == '0);
  assign cnt_ok   = digits_ok(cnt_q);
  assign load_ok  = digits_ok(bus.load_val) && (bus.load_val <= MAX_BCD);
  assign cnt_step = bcd_step(cnt_q, dir_up);

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.load) begin
      // A load in the same cycle as en swallows the count step.
      if (load_ok) cnt_q <= bus.load_val;
      wrap_q     <= 1'b0;
      load_err_q <= !load_ok;
    end else if (bus.en) begin
      load_err_q <= 1'b0;
      if (!cnt_ok) begin
        // Unreachable in normal operation; recovers a corrupted count.
        cnt_q  <= '0;
        wrap_q <= 1'b0;
      end else if (at_end) begin
        cnt_q  <= dir_up ? '0 : MAX_BCD;
        wrap_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_step;
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.tc       = at_end;
  assign bus.carry    = bus.en & at_end;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_counter_bcd_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_bcd_mod
// Self-checking bench for counter_bcd_mod: a mod-60 stage driven directly,
// a cascaded mod-60 -> mod-60 -> mod-24 chain, and a standalone mod-24 stage.
// -----------------------------------------------------------------------------
module tb_counter_bcd_mod;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic [7:0] load_val;
    logic [7:0] exp_cnt;
    logic       exp_wrap;
    logic       exp_err;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[18];

  counter_bcd_mod_if #(.DIGITS(2)) sec_if ();
  counter_bcd_mod_if #(.DIGITS(2)) min_if ();
  counter_bcd_mod_if #(.DIGITS(2)) hr_if ();
  counter_bcd_mod_if #(.DIGITS(2)) h24_if ();

  counter_bcd_mod #(.DIGITS(2), .MODULUS(60)) u_sec (.clk(clk), .rst(rst), .bus(sec_if));
  counter_bcd_mod #(.DIGITS(2), .MODULUS(60)) u_min (.clk(clk), .rst(rst), .bus(min_if));
  counter_bcd_mod #(.DIGITS(2), .MODULUS(24)) u_hr  (.clk(clk), .rst(rst), .bus(hr_if));
  counter_bcd_mod #(.DIGITS(2), .MODULUS(24)) u_h24 (.clk(clk), .rst(rst), .bus(h24_if));

  assign min_if.en = sec_if.carry;
  assign hr_if.en  = min_if.carry;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- helpers ----------------
  function automatic logic [7:0] to_bcd2(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_sec(input logic c, input logic l, input logic e, input logic [7:0] lv);
    sec_if.clr      = c;
    sec_if.load     = l;
    sec_if.en       = e;
    sec_if.load_val = lv;
  endtask

  task automatic drive_h24(input logic c, input logic l, input logic e, input logic [7:0] lv);
    h24_if.clr      = c;
    h24_if.load     = l;
    h24_if.en       = e;
    h24_if.load_val = lv;
  endtask

  // ---------------- stimulus ----------------
  int         m;
  int         n;
  logic       r_c, r_l, r_e, exp_w, exp_e;
  logic [7:0] r_lv;
  logic [7:0] exp_cnt;

  initial begin
    rst = 1'b1;
    sec_if.up = 1'b1;
    h24_if.up = 1'b1;
    drive_sec(1'b0, 1'b0, 1'b0, 8'h00);
    drive_h24(1'b0, 1'b0, 1'b0, 8'h00);
    min_if.clr = 1'b0; min_if.load = 1'b0; min_if.load_val = 8'h00; min_if.up = 1'b1;
    hr_if.clr  = 1'b0; hr_if.load  = 1'b0; hr_if.load_val  = 8'h00; hr_if.up  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_cnt",   32'(sec_if.cnt), 32'h00);
    check("rst_wrap",  32'(sec_if.wrap), 32'h0);
    check("rst_err",   32'(sec_if.load_err), 32'h0);
    check("rst_tc",    32'(sec_if.tc), 32'h0);
    check("rst_carry", 32'(sec_if.carry), 32'h0);
    check("rst_hr",    32'(hr_if.cnt), 32'h00);

    // Table-driven vectors on the mod-60 stage, applied in order from cnt 00
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h37, 8'h37, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h42, 8'h42, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h43, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h1A, 8'h43, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h43, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h60, 8'h43, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h59, 8'h59, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h09, 8'h09, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'hA0, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h59, 8'h59, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 18; i++) begin
      drive_sec(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].load_val);
      tick();
      check($sformatf("vec%0d_cnt", i),  32'(sec_if.cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_wrap", i), 32'(sec_if.wrap), 32'(vecs[i].exp_wrap));
      check($sformatf("vec%0d_err", i),  32'(sec_if.load_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_tc", i),   32'(sec_if.tc), 32'(vecs[i].exp_tc));
    end
    drive_sec(1'b0, 1'b0, 1'b0, 8'h00);

    // Full sweep 00..59 with en held high
    do_reset();
    sec_if.en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      check($sformatf("sweep%0d_cnt", i),   32'(sec_if.cnt), 32'(to_bcd2(i)));
      check($sformatf("sweep%0d_tc", i),    32'(sec_if.tc), 32'(i == 59));
      check($sformatf("sweep%0d_carry", i), 32'(sec_if.carry), 32'(i == 59));
      tick();
    end
    check("sweep_wrap_cnt", 32'(sec_if.cnt), 32'h00);
    check("sweep_wrap",     32'(sec_if.wrap), 32'h1);
    sec_if.en = 1'b0;
    check("sweep_carry_en_low", 32'(sec_if.carry), 32'h0);
    tick();
    check("sweep_wrap_one_cycle", 32'(sec_if.wrap), 32'h0);

    // Mod-24 preset and range check
    drive_h24(1'b0, 1'b1, 1'b0, 8'h23);
    tick();
    check("h24_load23", 32'(h24_if.cnt), 32'h23);
    check("h24_tc23",   32'(h24_if.tc), 32'h1);
    drive_h24(1'b0, 1'b0, 1'b1, 8'h00);
    #1;
    check("h24_carry23", 32'(h24_if.carry), 32'h1);
    tick();
    check("h24_wrap_cnt", 32'(h24_if.cnt), 32'h00);
    check("h24_wrap",     32'(h24_if.wrap), 32'h1);
    drive_h24(1'b0, 1'b1, 1'b0, 8'h24);
    tick();
    check("h24_load24_err", 32'(h24_if.load_err), 32'h1);
    check("h24_load24_cnt", 32'(h24_if.cnt), 32'h00);
    check("h24_load24_nowrap", 32'(h24_if.wrap), 32'h0);
    drive_h24(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check("h24_err_one_cycle", 32'(h24_if.load_err), 32'h0);

`ifdef COUNTER_BCD_DOWN_EN
    // Down counting on the mod-60 stage
    sec_if.up = 1'b0;
    drive_sec(1'b0, 1'b1, 1'b0, 8'h10);
    tick();
    drive_sec(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    check("down_10_to_09", 32'(sec_if.cnt), 32'h09);
    drive_sec(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check("down_tc0", 32'(sec_if.tc), 32'h1);
    drive_sec(1'b0, 1'b0, 1'b1, 8'h00);
    #1;
    check("down_carry0", 32'(sec_if.carry), 32'h1);
    tick();
    check("down_wrap_cnt", 32'(sec_if.cnt), 32'h59);
    check("down_wrap",     32'(sec_if.wrap), 32'h1);
    drive_sec(1'b0, 1'b0, 1'b0, 8'h00);
    sec_if.up = 1'b1;
`endif

    // Randomized stimulus against a decimal reference model
    do_reset();
    m = 0;
    for (int i = 0; i < 400; i++) begin
      r_c = ($urandom_range(0, 19) == 0);
      r_l = ($urandom_range(0, 5) == 0);
      r_e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) r_lv = to_bcd2($urandom_range(0, 59));
      else                           r_lv = 8'($urandom_range(0, 255));
      drive_sec(r_c, r_l, r_e, r_lv);
      #1;
      check("rand_tc",    32'(sec_if.tc), 32'(m == 59));
      check("rand_carry", 32'(sec_if.carry), 32'(r_e && (m == 59)));
      exp_w = 1'b0;
      exp_e = 1'b0;
      if (r_c) begin
        m = 0;
      end else if (r_l) begin
        if (r_lv[7:4] <= 4'd9 && r_lv[3:0] <= 4'd9 &&
            (int'(r_lv[7:4]) * 10 + int'(r_lv[3:0])) < 60)
          m = int'(r_lv[7:4]) * 10 + int'(r_lv[3:0]);
        else
          exp_e = 1'b1;
      end else if (r_e) begin
        m = (m + 1) % 60;
        exp_w = (m == 0);
      end
      exp_q.push_back(to_bcd2(m));
      tick();
      exp_cnt = exp_q.pop_front();
      check("rand_cnt",  32'(sec_if.cnt), 32'(exp_cnt));
      check("rand_wrap", 32'(sec_if.wrap), 32'(exp_w));
      check("rand_err",  32'(sec_if.load_err), 32'(exp_e));
    end
    drive_sec(1'b0, 1'b0, 1'b0, 8'h00);

    // Cascade: seconds -> minutes -> hours, model is a plain event count
    do_reset();
    n = 0;
    sec_if.en = 1'b1;
    for (int i = 0; i < 3600; i++) begin
      tick();
      n++;
    end
    check("casc_hr",  32'(hr_if.cnt),  32'h01);
    check("casc_min", 32'(min_if.cnt), 32'h00);
    check("casc_sec", 32'(sec_if.cnt), 32'h00);
    for (int i = 0; i < 1500; i++) begin
      r_e = ($urandom_range(0, 3) != 0);
      sec_if.en = r_e;
      tick();
      if (r_e) n++;
      check("casc_r_sec", 32'(sec_if.cnt), 32'(to_bcd2(n % 60)));
      check("casc_r_min", 32'(min_if.cnt), 32'(to_bcd2((n / 60) % 60)));
      check("casc_r_hr",  32'(hr_if.cnt),  32'(to_bcd2((n / 3600) % 24)));
    end
    sec_if.en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sec_if.en = 1'b0;
    check("casc_rst_sec", 32'(sec_if.cnt), 32'h00);
    check("casc_rst_min", 32'(min_if.cnt), 32'h00);
    check("casc_rst_hr",  32'(hr_if.cnt),  32'h00);
    check("casc_rst_wrap", 32'(sec_if.wrap), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
